cache_controller_wb: RTL
========================

// Module: cache_controller_wb
// PURPOSE
// - Parametrised N-way set-associative write-back data cache. Sits in MEM stage between pipeline and SRAM_Controller.
// - Drives ready low to freeze the pipeline on a miss, so the pipeline freezes while (MEM_R_EN|MEM_W_EN)&~ready.
// - Adds dirty-line eviction, pseudo-LRU replacement and a whole-cache flush sequence.
// PARAMETERS
// - WAYS    2   associativity; legal values 2 or 4
// - SETS    64  sets; power of 2; IDX_W = log2(SETS)
// - ADDR_W  19  byte-address bits used; tag width = ADDR_W-3-IDX_W
// - Line size is fixed at 2x32-bit words (64 bit), matching the SRAM_Controller read burst.
// PORTS
// - clk          in   1   single clock, rising edge
// - rst          in   1   asynchronous, active-high reset
// - address      in   32  byte address from MEM stage; [1:0] ignored, [2] word select, [IDX_W+2:3] index
// - wdata        in   32  store data
// - MEM_R_EN     in   1   load request
// - MEM_W_EN     in   1   store request
// - flush        in   1   one-cycle pulse: write back all dirty lines, invalidate all
// - rdata        out  32  load data; valid when MEM_R_EN & ready
// - ready        out  1   request completes this cycle; 1 when idle
// - flush_busy   out  1   high from flush acceptance until done
// - sram_address out  32  word byte-address to SRAM_Controller, zero-extended, [1:0]=0
// - sram_wdata   out  32  eviction write data
// - write        out  1   SRAM write request, held until sram_ready
// - read         out  1   SRAM 64-bit line read request, held until sram_ready
// - sram_rdata   in   64  line from SRAM; [31:0] = word 0
// - sram_ready   in   1   SRAM op done, one-cycle pulse
// BEHAVIOUR
// - Reset: all valid, dirty and PLRU bits cleared; state IDLE.
//   Outputs at reset: ready=1, rdata=0, flush_busy=0, read=0, write=0, sram_address=0, sram_wdata=0.
//   Data and tag arrays are not reset.
// - Reset mid-miss or mid-flush aborts immediately; the in-flight SRAM op is abandoned.
// - Hit: combinational in IDLE.
//   Load: ready=1 and rdata = hit word in the same cycle.
//   Store: word written and dirty set at the clk edge, ready=1 in the same cycle.
//   Either hit updates PLRU toward the hit way.
// - Miss: ready=0. Victim = first invalid way (lowest index), else the PLRU way.
//   The victim is chosen when the miss is detected in IDLE and held in a register for the rest of the sequence.
//   Path when the victim is dirty: IDLE -> WB0 -> WB1 -> FILL -> IDLE.
//   Path when the victim is clean: IDLE -> FILL -> IDLE.
//   WB0/WB1: write=1 with the victim tag/index address for word 0/1; advance on sram_ready.
//   FILL: read=1 with the line base address; on sram_ready, write the line and tag, set valid=1, clear dirty.
//   Back in IDLE the request re-evaluates as a hit, giving ready=1.
//   Miss latency = 1 + SRAM ops + 1 cycles.
// - MEM_R_EN and MEM_W_EN both high: treated as a store. The request must be held stable until ready; changing it is a protocol violation.
// - Flush: accepted only in IDLE with no request; otherwise ignored.
//   Sequence: FL_SCAN walks set 0..SETS-1, way 0..WAYS-1 using a counter.
//   A dirty line takes FL_WB0 then FL_WB1 (same handshake as WB0/WB1), then valid and dirty are cleared.
//   The counter wraps past the last set/way back to IDLE, with flush_busy=0 on that edge.
//   flush_busy=1 and ready=0 throughout. A request arriving during a flush waits.
// - PLRU: WAYS-1 tree bits per set. WAYS=2: 1 bit, pointing to the not-recently-used way.
// - Never assert read and write together. Outputs come from registered state, except rdata/ready on a hit.
// STRUCTURE
// - Shared header cache_defs.vh: state encodings (IDLE, WB0, WB1, FILL, FL_SCAN, FL_WB0, FL_WB1), LINE_WORDS=2, field-slice macros.
// - Sub-module plru_tree #(WAYS): inputs = tree bits and access way; outputs = next bits and victim way. Purely combinational.
// - Arrays (data/tag/valid/dirty/plru) and the FSM live in this file.
// TESTING
// - WAYS=2, SETS=64; the SRAM model returns sram_ready 4 cycles after read/write rises.
// - Reset, then load 0x000: read=1 with sram_address=0x0; return sram_rdata=64'h22222222_11111111.
//   Required: rdata=0x11111111 with ready=1 one cycle after the FILL completes.
//   Then load 0x004: hit, rdata=0x22222222 with ready=1 in the same cycle, and read is never asserted.
// - Store 0x000=0xAAAA0000 (hit, ready the same cycle).
//   Then load 0x200 and 0x400 (same set 0, all ways filled); the victim way-0 line is dirty.
//   Required: write to 0x000 with 0xAAAA0000, then write to 0x004 with 0x22222222, then the read of 0x400.
// - PLRU: fill 0x000 and 0x200, load 0x000, then miss on 0x400.
//   Required: the way holding 0x200 is evicted; a load of 0x000 still hits.
// - Flush with 2 dirty lines in sets 0 and 5: exactly 4 writes occur in set order.
//   flush_busy drops after the scan; every subsequent load misses.
// - Assert rst while in WB1: all outputs take their reset values asynchronously.
//   After release, a load of 0x000 misses.
// - MEM_R_EN=MEM_W_EN=1 on a hit: the store is performed and the dirty bit is set.

Source files
------------

// File: rtl/cache_controller_wb_pkg.sv
// Shared types for the write-back data cache: FSM state encoding and line geometry.
// A line is two 32-bit words, matching the 64-bit SRAM read burst.
package cache_controller_wb_pkg;

  localparam int LINE_WORDS = 2;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    WB0,
    WB1,
    FILL,
    FL_SCAN,
    FL_WB0,
    FL_WB1
  } state_e;

  function automatic logic is_flush_state(input state_e s);
    return (s == FL_SCAN) || (s == FL_WB0) || (s == FL_WB1);
  endfunction

endpackage

// File: rtl/cache_controller_wb_plru_tree.sv
// Tree pseudo-LRU for one set: next tree bits after touching a way, and the current victim.
// Each bit points at the half that was NOT used most recently.
module plru_tree #(
  parameter int WAYS  = 2,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits_i,
  input  logic [WAY_W-1:0] way_i,
  output logic [WAYS-2:0]  bits_o,
  output logic [WAY_W-1:0] victim_o
);

  if (WAYS == 2) begin : g_two
    assign bits_o   = ~way_i;
    assign victim_o = bits_i;
  end else begin : g_four
    // bit 0 = root, bit 1 = pair {0,1}, bit 2 = pair {2,3}
    always_comb begin
      bits_o = bits_i;
      if (!way_i[1]) begin
        bits_o[0] = 1'b1;
        bits_o[1] = ~way_i[0];
      end else begin
        bits_o[0] = 1'b0;
        bits_o[2] = ~way_i[0];
      end
    end
    assign victim_o = bits_i[0] ? {1'b1, bits_i[2]} : {1'b0, bits_i[1]};
  end

endmodule

// File: rtl/cache_controller_wb.sv
// N-way set-associative write-back data cache between the MEM stage and the SRAM controller.
// Hits complete combinationally in IDLE; misses evict (if dirty) then fill; flush writes back everything.
module cache_controller_wb
  import cache_controller_wb_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int ADDR_W = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        flush,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        flush_busy,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  output logic        write,
  output logic        read,
  input  logic [63:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 3 - IDX_W;
  localparam int WAY_W = $clog2(WAYS);
  localparam int CNT_W = IDX_W + WAY_W;
  localparam int PAD_W = 32 - ADDR_W;

  state_e state_q, state_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SETS-1:0][WAYS-1:0] valid_q;
  logic [SETS-1:0][WAYS-1:0] dirty_q;
  logic [SETS-1:0][WAYS-2:0] plru_q;

  logic             req, is_store, req_word;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;

  logic [WAYS-1:0][LINE_W-1:0] line_rd, line_vrd;
  logic [WAYS-1:0][TAG_W-1:0]  tag_rd, tag_vrd;
  logic [WAYS-1:0]             hit_vec;

  logic             hit, any_inv;
  logic [WAY_W-1:0] hit_way, inv_way, plru_victim, vic_way;
  logic [WAYS-2:0]  plru_next;
  logic [31:0]      hit_word;
  logic             hit_upd, store_we, fill_done, line_clr;
  logic [IDX_W-1:0] cnt_set;
  logic [WAY_W-1:0] cnt_way;
  logic [LINE_W-1:0] vline;
  logic [TAG_W-1:0]  vtag;
  logic              unused_addr;

  assign req         = MEM_R_EN | MEM_W_EN;
  assign is_store    = MEM_W_EN;
  assign req_word    = address[2];
  assign req_idx     = address[IDX_W+2:3];
  assign req_tag     = address[ADDR_W-1:IDX_W+3];
  assign unused_addr = ^{address[31:ADDR_W], address[1:0]};
  assign cnt_set     = cnt_q[CNT_W-1:WAY_W];
  assign cnt_way     = cnt_q[WAY_W-1:0];
  assign store_we    = hit_upd & is_store;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    logic [LINE_W-1:0] data_mem [SETS];
    logic [TAG_W-1:0]  tag_mem  [SETS];

    always_ff @(posedge clk) begin
      if (fill_done && way_q == WAY_W'(gi)) begin
        data_mem[idx_q] <= sram_rdata;
        tag_mem[idx_q]  <= tag_q;
      end else if (store_we && hit_way == WAY_W'(gi)) begin
        if (req_word) data_mem[req_idx][63:32] <= wdata;
        else          data_mem[req_idx][31:0]  <= wdata;
      end
    end

    // Two read ports: the live request, and the line held by the eviction sequence.
    assign line_rd[gi]  = data_mem[req_idx];
    assign tag_rd[gi]   = tag_mem[req_idx];
    assign line_vrd[gi] = data_mem[idx_q];
    assign tag_vrd[gi]  = tag_mem[idx_q];
    assign hit_vec[gi]  = valid_q[req_idx][gi] && (tag_rd[gi] == req_tag);
  end

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_idx][w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign hit      = |hit_vec;
  assign hit_word = req_word ? line_rd[hit_way][63:32] : line_rd[hit_way][31:0];
  assign vic_way  = any_inv ? inv_way : plru_victim;
  assign vline    = line_vrd[way_q];
  assign vtag     = tag_vrd[way_q];

  plru_tree #(.WAYS(WAYS), .WAY_W(WAY_W)) u_plru (
    .bits_i   (plru_q[req_idx]),
    .way_i    (hit_way),
    .bits_o   (plru_next),
    .victim_o (plru_victim)
  );

  assign flush_busy = is_flush_state(state_q);

  always_comb begin
    state_d      = state_q;
    way_d        = way_q;
    idx_d        = idx_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    ready        = 1'b0;
    rdata        = '0;
    read         = 1'b0;
    write        = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    hit_upd      = 1'b0;
    fill_done    = 1'b0;
    line_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          if (hit) begin
            hit_upd = 1'b1;
            if (MEM_R_EN) rdata = hit_word;
          end else begin
            ready   = 1'b0;
            way_d   = vic_way;
            idx_d   = req_idx;
            tag_d   = req_tag;
            state_d = (valid_q[req_idx][vic_way] && dirty_q[req_idx][vic_way]) ? WB0 : FILL;
          end
        end else if (flush) begin
          cnt_d   = '0;
          state_d = FL_SCAN;
        end
      end
      WB0, FL_WB0: begin
        write        = 1'b1;
        sram_address = {{PAD_W{1'b0}}, vtag, idx_q, 3'b000};
        sram_wdata   = vline[31:0];
        if (sram_ready) state_d = (state_q == WB0) ? WB1 : FL_WB1;
      end
      WB1: begin
        write        = 1'b1;
        sram_address = {{PAD_W{1'b0}}, vtag, idx_q, 3'b100};
        sram_wdata   = vline[63:32];
        if (sram_ready) state_d = FILL;
      end
      FILL: begin
        read         = 1'b1;
        sram_address = {{PAD_W{1'b0}}, tag_q, idx_q, 3'b000};
        if (sram_ready) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      FL_SCAN: begin
        if (valid_q[cnt_set][cnt_way] && dirty_q[cnt_set][cnt_way]) begin
          idx_d   = cnt_set;
          way_d   = cnt_way;
          state_d = FL_WB0;
        end else begin
          line_clr = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (&cnt_q) state_d = IDLE;
        end
      end
      FL_WB1: begin
        write        = 1'b1;
        sram_address = {{PAD_W{1'b0}}, vtag, idx_q, 3'b100};
        sram_wdata   = vline[63:32];
        if (sram_ready) begin
          line_clr = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = (&cnt_q) ? IDLE : FL_SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      way_q   <= '0;
      idx_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      plru_q  <= '0;
    end else begin
      state_q <= state_d;
      way_q   <= way_d;
      idx_q   <= idx_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      if (hit_upd) begin
        plru_q[req_idx] <= plru_next;
        if (is_store) dirty_q[req_idx][hit_way] <= 1'b1;
      end
      if (fill_done) begin
        valid_q[idx_q][way_q] <= 1'b1;
        dirty_q[idx_q][way_q] <= 1'b0;
      end
      if (line_clr) begin
        valid_q[cnt_set][cnt_way] <= 1'b0;
        dirty_q[cnt_set][cnt_way] <= 1'b0;
      end
    end
  end

endmodule
